// File: rtl/app_hard_decision_unloader.sv
// Streams sign-bit hard decisions of the APP memory out one Z-lane group per
// cycle over valid/ready, and accumulates the Hamming weight of the frame.
module app_hard_decision_unloader #(
  parameter int Z        = 52,
  parameter int N_GROUPS = 52,
  parameter int Q        = 6,
  parameter int K_GROUPS = 52,
  localparam int AW      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int WW      = $clog2(K_GROUPS * Z + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [Q-1:0]  rd_data [Z],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Z-1:0]  out_bits,
  output logic [AW-1:0] out_group,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [WW-1:0] frame_weight
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int PW = $clog2(Z + 1);
  localparam logic [AW-1:0] LAST_G = AW'(K_GROUPS - 1);

  function automatic logic [PW-1:0] popcount(input logic [Z-1:0] v);
    logic [PW-1:0] n;
    n = {PW{1'b0}};
    for (int i = 0; i < Z; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  logic [1:0]    state;
  logic [AW-1:0] f;
  logic [Z-1:0]  signs;
  logic          load;
  logic          handshake;

  // Sign bit of every lane is the hard decision (negative LLR -> 1).
  always_comb begin
    signs = {Z{1'b0}};
    for (int i = 0; i < Z; i++) begin
      signs[i] = rd_data[i][Q-1];
    end
  end

  // The start cycle itself loads group 0; RUN reloads whenever the slot frees.
  always_comb begin
    case (state)
      IDLE:    load = start;
      RUN:     load = ~out_valid | out_ready;
      DRAIN:   load = 1'b0;
      default: load = 1'b0;
    endcase
  end

  assign handshake = out_valid & out_ready;
  assign rd_addr   = f;

  // FSM, fetch index, output register and weight accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      f            <= {AW{1'b0}};
      out_valid    <= 1'b0;
      out_bits     <= {Z{1'b0}};
      out_group    <= {AW{1'b0}};
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_weight <= {WW{1'b0}};
    end else begin
      done <= 1'b0;
      if (load) begin
        out_bits  <= signs;
        out_group <= f;
        out_last  <= (f == LAST_G);
        out_valid <= 1'b1;
        busy      <= 1'b1;
        if (f == LAST_G) begin
          f     <= {AW{1'b0}};
          state <= DRAIN;
        end else begin
          f     <= f + AW'(1);
          state <= RUN;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
        if (state == DRAIN) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end

      // A start is only accepted in IDLE, where no beat can be in flight.
      if ((state == IDLE) && start) begin
        frame_weight <= {WW{1'b0}};
      end else if (handshake) begin
        frame_weight <= frame_weight + WW'(popcount(out_bits));
      end
    end
  end

endmodule

// File: doc/app_hard_decision_unloader.md
# app_hard_decision_unloader

Reads the final APP LLRs out of the decoder's APP memory one Z-lane group per cycle after decoding has converged or hit its iteration limit. Takes the sign-bit hard decision for every lane and streams the decoded bits downstream over a valid/ready handshake. Accumulates the Hamming weight of the decoded frame. Sits on the read port of the APP memory, opposite the write-side loader and the check-node update path.

## Interface

Parameters:
- Z, 52, lanes per group, equal to the expansion factor.
- N_GROUPS, 52, number of groups in the APP memory; sets the address width AW = $clog2(N_GROUPS).
- Q, 6, LLR width in two's complement.
- K_GROUPS, 52, number of groups unloaded per frame; legal range 1..N_GROUPS.

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request to unload one frame.
- rd_addr, output, AW: APP memory read address.
- rd_data, input, Q x Z (unpacked [Z]): APP memory read data, combinational from rd_addr.
- out_valid, output, 1: out_bits holds a valid group.
- out_ready, input, 1: the downstream sink accepts the group.
- out_bits, output, Z: hard decisions for one group; bit i = rd_data[i][Q-1].
- out_group, output, AW: index of the group in out_bits.
- out_last, output, 1: asserted with group K_GROUPS-1.
- busy, output, 1: a frame unload is in progress.
- done, output, 1: one-cycle pulse after the final handshake.
- frame_weight, output, $clog2(K_GROUPS*Z+1): count of ones across the frame.

## Operation

- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1; issues reads and loads the output register.
  - DRAIN: busy=1; the last group is loaded and is waiting for its handshake.
- Fetch index f (AW bits) drives rd_addr directly. rd_addr = 0 in IDLE.
- IDLE -> RUN on start. The start cycle also loads group 0, so the start cycle is the first load.
- Load condition: in RUN and (!out_valid || out_ready). A load does the following:
  - out_bits <= sign bits of rd_data.
  - out_group <= f.
  - out_last <= (f == K_GROUPS-1).
  - out_valid <= 1.
  - f <= f+1, or 0 after the last group, with the FSM going to DRAIN.
- A handshake without a new load clears out_valid.
- DRAIN -> IDLE on the handshake of the last beat. done=1 in the next cycle, with busy=0 in that same cycle.
- Hard decision: a negative LLR gives 1. Zero and positive LLRs give 0. The most negative code (e.g. 6'h20) gives 1.
- frame_weight:
  - Cleared to 0 on accepted start.
  - Adds popcount(out_bits) on each handshake.
  - Holds its value after done until the next start.
  - Cannot overflow, because its width covers K_GROUPS*Z.
- start while busy=1 is ignored. start in the done cycle is accepted, because the FSM is already in IDLE.
- APP memory contents must stay static from start to done. This is the upstream's responsibility and is not checked here.

## Timing

- Reset value of every output is 0: rd_addr, out_valid, out_bits, out_group, out_last, busy, done, frame_weight.
- Reset asserted mid-frame aborts the frame immediately. No done is issued and no partial beat is presented afterwards.
- Latency, with start accepted at cycle T: group 0 is valid at T+1.
- With out_ready held at 1, group g is valid at T+1+g and out_last is valid at T+K_GROUPS.
- Final handshake at cycle E: done=1 and busy=0 at E+1.
- Throughput is one group per cycle under continuous ready.
- While out_valid && !out_ready, the following hold stable: out_bits, out_group, out_last, and rd_addr. No group is skipped or duplicated.
- out_valid never depends combinationally on out_ready. All outputs are registered except rd_addr, which comes from the f register.
- K_GROUPS=1: start at T gives a beat at T+1 with out_last=1, and the FSM goes straight to DRAIN.

## Test plan

- Load memory[g][i] = (i+g) odd ? -1 : +1, hold out_ready=1, pulse start at T. Require:
  - Groups 0..51 on consecutive cycles T+1..T+52, each with the alternating pattern.
  - out_last only on group 51.
  - done at T+53.
  - frame_weight = 1352.
- Hold out_ready=0 for 5 cycles at group 10, then drive a 1,0,1,0 pattern. Require out_bits, out_group and rd_addr stable while stalled, groups 10..51 each accepted exactly once in order, and done one cycle after the last handshake.
- Weight and sign checks:
  - All lanes 6'h3F: out_bits all ones, frame_weight = 2704.
  - All lanes 6'h00 or 6'h1F: frame_weight = 0.
  - All lanes 6'h20: frame_weight = 2704.
- Pulse start at cycles T+5 and T+20 of an active frame: both are ignored, with no restart and no change in frame_weight. Pulse start again in the done cycle: group 0 is valid the next cycle and frame_weight is cleared.
- Assert rst_n=0 after group 10 is accepted. Require all outputs 0 asynchronously and no done. After release, a new start unloads from group 0 with the correct weight.
- Build with K_GROUPS=1 and the same sequence as the first scenario. Require a single beat with out_last=1, done two cycles after start, and frame_weight = popcount of group 0.
